// File: rtl/textdisp_console.sv
// Character console front-end for the 32x28 text overlay.
// Decodes byte-wide register writes and keeps a hardware cursor. Each request
// becomes single-cell writes on the display's registered write port.
// The multi-cycle row erase and screen clear run in the ERASE_ROW and CLEAR states.
// Register writes are accepted only in IDLE. busy = (state != IDLE).
// The state register is held one cycle past the last cell load. This keeps busy
// high while the final write pulse is on the port, so busy drops in the cycle
// after the last we pulse.
module textdisp_console #(
    parameter int         COLS  = 32,
    parameter int         ROWS  = 28,
    parameter logic [6:0] BLANK = 7'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic       busy,
    output logic [4:0] cursor_x,
    output logic [4:0] cursor_y,
    output logic [4:0] x_wr,
    output logic [4:0] y_wr,
    output logic [6:0] char_wr,
    output logic       we
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ERASE_ROW = 2'd1,
        CLEAR     = 2'd2
    } state_t;

    localparam logic [4:0] LAST_COL  = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [9:0] LAST_CELL = 10'(COLS * ROWS - 1);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    // Set when a wrapping character defers the erase of the new row by one cycle
    logic       erase_pend_q, erase_pend_d;
    logic [4:0] cx_q, cx_d;
    logic [4:0] cy_q, cy_d;
    logic [4:0] x_wr_q, x_wr_d;
    logic [4:0] y_wr_q, y_wr_d;
    logic [6:0] char_wr_q, char_wr_d;
    logic       we_q, we_d;

    logic [4:0] next_row;
    logic       printable;

    assign next_row  = (cy_q == LAST_ROW) ? 5'd0 : cy_q + 5'd1;
    assign printable = reg_wdata[7] | ((reg_wdata >= 8'h20) && (reg_wdata <= 8'h7E));

    // Next-state, cursor and display-write decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        erase_pend_d = erase_pend_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        x_wr_d       = x_wr_q;
        y_wr_d       = y_wr_q;
        char_wr_d    = char_wr_q;
        we_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (reg_we) begin
                    case (reg_addr)
                        2'd0: begin
                            if (printable) begin
                                x_wr_d    = cx_q;
                                y_wr_d    = cy_q;
                                char_wr_d = reg_wdata[7] ? 7'h3F : reg_wdata[6:0];
                                we_d      = 1'b1;
                                if (cx_q == LAST_COL) begin
                                    cx_d         = 5'd0;
                                    cy_d         = next_row;
                                    erase_pend_d = 1'b1;
                                    state_d      = ERASE_ROW;
                                end else begin
                                    cx_d = cx_q + 5'd1;
                                end
                            end else begin
                                case (reg_wdata)
                                    8'h0A: begin
                                        // Line feed: first erase cell issued now
                                        cx_d         = 5'd0;
                                        cy_d         = next_row;
                                        x_wr_d       = 5'd0;
                                        y_wr_d       = next_row;
                                        char_wr_d    = BLANK;
                                        we_d         = 1'b1;
                                        cnt_d        = 10'd0;
                                        erase_pend_d = 1'b0;
                                        state_d      = ERASE_ROW;
                                    end
                                    8'h0D: cx_d = 5'd0;
                                    8'h08: begin
                                        if (cx_q != 5'd0) begin
                                            cx_d      = cx_q - 5'd1;
                                            x_wr_d    = cx_q - 5'd1;
                                            y_wr_d    = cy_q;
                                            char_wr_d = BLANK;
                                            we_d      = 1'b1;
                                        end
                                    end
                                    8'h0C: begin
                                        x_wr_d    = 5'd0;
                                        y_wr_d    = 5'd0;
                                        char_wr_d = BLANK;
                                        we_d      = 1'b1;
                                        cnt_d     = 10'd0;
                                        state_d   = CLEAR;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                        2'd1: cx_d = reg_wdata[4:0];
                        2'd2: cy_d = (reg_wdata[4:0] > LAST_ROW) ? LAST_ROW : reg_wdata[4:0];
                        default: begin
                            if (reg_wdata[0]) begin
                                x_wr_d    = 5'd0;
                                y_wr_d    = 5'd0;
                                char_wr_d = BLANK;
                                we_d      = 1'b1;
                                cnt_d     = 10'd0;
                                state_d   = CLEAR;
                            end
                        end
                    endcase
                end
            end
            ERASE_ROW: begin
                if (erase_pend_q) begin
                    erase_pend_d = 1'b0;
                    cnt_d        = 10'd0;
                    x_wr_d       = 5'd0;
                    y_wr_d       = cy_q;
                    char_wr_d    = BLANK;
                    we_d         = 1'b1;
                end else if (cnt_q[4:0] == LAST_COL) begin
                    state_d = IDLE;
                end else begin
                    cnt_d     = cnt_q + 10'd1;
                    x_wr_d    = cnt_q[4:0] + 5'd1;
                    y_wr_d    = cy_q;
                    char_wr_d = BLANK;
                    we_d      = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_CELL) begin
                    state_d = IDLE;
                    cx_d    = 5'd0;
                    cy_d    = 5'd0;
                end else begin
                    cnt_d     = cnt_q + 10'd1;
                    x_wr_d    = cnt_d[4:0];
                    y_wr_d    = cnt_d[9:5];
                    char_wr_d = BLANK;
                    we_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, cursor and registered display port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 10'd0;
            erase_pend_q <= 1'b0;
            cx_q         <= 5'd0;
            cy_q         <= 5'd0;
            x_wr_q       <= 5'd0;
            y_wr_q       <= 5'd0;
            char_wr_q    <= 7'd0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            erase_pend_q <= erase_pend_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            x_wr_q       <= x_wr_d;
            y_wr_q       <= y_wr_d;
            char_wr_q    <= char_wr_d;
            we_q         <= we_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign cursor_x = cx_q;
    assign cursor_y = cy_q;
    assign x_wr     = x_wr_q;
    assign y_wr     = y_wr_q;
    assign char_wr  = char_wr_q;
    assign we       = we_q;

endmodule

// File: tb/tb_textdisp_console.sv
// Directed bench for textdisp_console.
// Inputs change on the falling edge and outputs are sampled there. The write
// task returns at the falling edge of the cycle after acceptance (N+1).
module tb_textdisp_console;

    logic       clk;
    logic       reset;
    logic       reg_we;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       busy;
    logic [4:0] cursor_x;
    logic [4:0] cursor_y;
    logic [4:0] x_wr;
    logic [4:0] y_wr;
    logic [6:0] char_wr;
    logic       we;

    int checks = 0;
    int errors = 0;

    textdisp_console dut (
        .clk      (clk),
        .reset    (reset),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .busy     (busy),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .x_wr     (x_wr),
        .y_wr     (y_wr),
        .char_wr  (char_wr),
        .we       (we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle register write; call at a falling edge
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        @(negedge clk);
        reg_we    = 1'b0;
    endtask

    task automatic chk_cell(input string tag, input logic w, input int x, input int y, input int c);
        chk({tag, "_we"}, 32'(we), 32'(w));
        if (w) begin
            chk({tag, "_x"}, 32'(x_wr), 32'(x));
            chk({tag, "_y"}, 32'(y_wr), 32'(y));
            chk({tag, "_char"}, 32'(char_wr), 32'(c));
        end
    endtask

    task automatic chk_cur(input string tag, input int x, input int y, input logic b);
        chk({tag, "_cx"}, 32'(cursor_x), 32'(x));
        chk({tag, "_cy"}, 32'(cursor_y), 32'(y));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    initial begin
        int bad;
        reset     = 1'b1;
        reg_we    = 1'b0;
        reg_addr  = 2'd0;
        reg_wdata = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset values
        chk_cur("rst", 0, 0, 1'b0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_xwr", 32'(x_wr), 32'd0);
        chk("rst_ywr", 32'(y_wr), 32'd0);
        chk("rst_char", 32'(char_wr), 32'd0);

        // Plain printable at (0,0)
        wr(2'd0, 8'h41);
        chk_cell("a", 1'b1, 0, 0, 'h41);
        chk_cur("a", 1, 0, 1'b0);
        @(negedge clk);
        chk_cell("a_after", 1'b0, 0, 0, 0);
        chk("a_after_busy", 32'(busy), 32'd0);

        // Wrap from (31,27): char, then row 0 erased
        wr(2'd1, 8'd31);
        wr(2'd2, 8'd27);
        chk_cur("setpos", 31, 27, 1'b0);
        chk("setpos_we", 32'(we), 32'd0);
        wr(2'd0, 8'h42);
        chk_cell("wrap_char", 1'b1, 31, 27, 'h42);
        chk_cur("wrap_char", 0, 0, 1'b1);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (!(we === 1'b1 && x_wr === 5'(k) && y_wr === 5'd0 && char_wr === 7'h20 && busy === 1'b1))
                bad++;
        end
        chk("wrap_erase_bad_cycles", 32'(bad), 32'd0);
        @(negedge clk);
        chk("wrap_done_busy", 32'(busy), 32'd0);
        chk("wrap_done_we", 32'(we), 32'd0);
        chk_cur("wrap_done", 0, 0, 1'b0);

        // Backspace
        wr(2'd1, 8'd5);
        wr(2'd0, 8'h08);
        chk_cell("bs1", 1'b1, 4, 0, 'h20);
        chk_cur("bs1", 4, 0, 1'b0);
        wr(2'd0, 8'h08);
        chk_cell("bs2", 1'b1, 3, 0, 'h20);
        chk_cur("bs2", 3, 0, 1'b0);
        wr(2'd1, 8'd0);
        wr(2'd0, 8'h08);
        chk("bs0_we", 32'(we), 32'd0);
        chk_cur("bs0", 0, 0, 1'b0);

        // Clear with writes attempted while busy
        wr(2'd1, 8'd7);
        wr(2'd2, 8'd3);
        wr(2'd3, 8'h01);
        chk_cell("clr0", 1'b1, 0, 0, 'h20);
        chk("clr0_busy", 32'(busy), 32'd1);
        bad = 0;
        for (int i = 1; i < 896; i++) begin
            if (i % 100 == 50) begin
                reg_we    = 1'b1;
                reg_addr  = (i % 200 == 50) ? 2'd0 : 2'd1;
                reg_wdata = 8'h55;
            end else begin
                reg_we = 1'b0;
            end
            @(negedge clk);
            if (!(we === 1'b1 && x_wr === 5'(i % 32) && y_wr === 5'(i / 32) && char_wr === 7'h20 && busy === 1'b1))
                bad++;
        end
        reg_we = 1'b0;
        chk("clr_bad_cycles", 32'(bad), 32'd0);
        chk_cur("clr_busy_end", 7, 3, 1'b1);
        @(negedge clk);
        chk("clr_done_we", 32'(we), 32'd0);
        chk_cur("clr_done", 0, 0, 1'b0);
        // Accepted in the same cycle busy drops
        wr(2'd0, 8'h43);
        chk_cell("post_clr", 1'b1, 0, 0, 'h43);
        chk_cur("post_clr", 1, 0, 1'b0);

        // Clamp, high code, ignored control, CR
        wr(2'd2, 8'd31);
        chk_cur("clamp", 1, 27, 1'b0);
        wr(2'd0, 8'h9A);
        chk_cell("hi", 1'b1, 1, 27, 'h3F);
        chk_cur("hi", 2, 27, 1'b0);
        wr(2'd0, 8'h07);
        chk("bel_we", 32'(we), 32'd0);
        chk_cur("bel", 2, 27, 1'b0);
        wr(2'd0, 8'h0D);
        chk("cr_we", 32'(we), 32'd0);
        chk_cur("cr", 0, 27, 1'b0);

        // Back-to-back printable characters
        wr(2'd0, 8'h61);
        chk_cell("b2b0", 1'b1, 0, 27, 'h61);
        wr(2'd0, 8'h62);
        chk_cell("b2b1", 1'b1, 1, 27, 'h62);
        chk_cur("b2b1", 2, 27, 1'b0);
        @(negedge clk);
        chk("b2b_after_we", 32'(we), 32'd0);

        // Form feed behaves as clear
        wr(2'd0, 8'h0C);
        chk_cell("ff0", 1'b1, 0, 0, 'h20);
        chk("ff0_busy", 32'(busy), 32'd1);
        repeat (895) @(negedge clk);
        chk_cell("ff_last", 1'b1, 31, 27, 'h20);
        chk("ff_last_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk_cur("ff_done", 0, 0, 1'b0);

        // Line feed aborted by reset at erase count 10
        wr(2'd1, 8'd4);
        wr(2'd2, 8'd5);
        wr(2'd0, 8'h0A);
        chk_cell("lf0", 1'b1, 0, 6, 'h20);
        chk_cur("lf0", 0, 6, 1'b1);
        repeat (10) @(negedge clk);
        chk_cell("lf10", 1'b1, 10, 6, 'h20);
        chk("lf10_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_abort_we", 32'(we), 32'd0);
        chk("rst_abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_we", 32'(we), 32'd0);
        chk_cur("post_rst", 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("post_rst_idle_we", 32'(we), 32'd0);
        chk("post_rst_idle_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/textdisp_console.md
# textdisp_console

Character console front-end for the 32x28 text overlay. It takes byte-wide register writes from the picorv32 bus and interprets printable characters and control codes. It keeps a hardware cursor and turns each request into single-cell writes on the text display's character-write port (`x_wr`/`y_wr`/`char_wr`/`we`). It sits directly upstream of the text display, in the main logic clock domain.

## Interface
Parameters:
- `COLS`, 32, columns per row (cursor X range 0..31)
- `ROWS`, 28, rows per screen (cursor Y range 0..27)
- `BLANK`, 7'h20, code written when erasing a cell

Ports:
- `clk`  in  1  main logic clock; the only clock
- `reset`  in  1  asynchronous, active-high reset
- `reg_we`  in  1  register write strobe, one cycle per access
- `reg_addr`  in  2  0=CHAR, 1=CURSOR_X, 2=CURSOR_Y, 3=CMD
- `reg_wdata`  in  8  write data
- `busy`  out  1  multi-cycle operation in progress; writes are dropped while high
- `cursor_x`  out  5  current cursor column
- `cursor_y`  out  5  current cursor row
- `x_wr`  out  5  display write column (registered)
- `y_wr`  out  5  display write row (registered)
- `char_wr`  out  7  display write code (registered)
- `we`  out  1  display write enable, one pulse per cell (registered)

## Operation
- States: IDLE, ERASE_ROW, CLEAR.
- A `reg_we` is accepted only in IDLE with `busy`=0. Writes arriving while busy are dropped, with no side effects.
- CHAR write, decoded on `reg_wdata`:
  - 0x20–0x7E: write the code at (cx,cy), then cx+1. From cx=31, go to cx=0 and cy+1, and enter ERASE_ROW for the new row.
  - 0x80–0xFF: treated as printable with code 0x3F ('?').
  - 0x0A LF: cx=0, cy+1, enter ERASE_ROW.
  - 0x0D CR: cx=0; no display write.
  - 0x08 BS: if cx>0, then cx-1 and write BLANK at the new cx. At cx=0, no-op.
  - 0x0C FF: same as CMD bit0.
  - All other codes below 0x20: ignored.
- Row advance wraps: cy=27 becomes 0. There is no scrolling; the destination row is erased instead.
- CURSOR_X write: cx = `reg_wdata[4:0]`.
- CURSOR_Y write: cy = `reg_wdata[4:0]`; values ≥28 clamp to 27.
- CMD write, bit0=1 → CLEAR. Other bits are ignored.
- ERASE_ROW: a 5-bit counter 0..31 writes BLANK at (counter, cy), then returns to IDLE. The cursor stays at (0,cy).
- CLEAR: a 10-bit counter 0..895 writes BLANK at (cnt[4:0], cnt[9:5]). On completion, cursor=(0,0) and state returns to IDLE.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE; `busy`=0; `cursor_x`=0, `cursor_y`=0; `x_wr`=0, `y_wr`=0, `char_wr`=0, `we`=0. Reset does not clear the screen.
- Reset asserted mid-ERASE_ROW or mid-CLEAR aborts immediately. `we` is 0 from the reset edge.
- Accepted write at cycle N:
  - Display outputs and the cursor update at N+1.
  - The written cell's `x_wr`/`y_wr` are the pre-advance cursor.
- Printable char without wrap: `we`=1 at N+1 only; `busy` stays 0. Back-to-back CHAR writes every cycle are allowed.
- Printable char with wrap: char write at N+1; erase writes at N+2..N+33; `busy`=1 for N+1..N+33.
- LF: erase writes at N+1..N+32, `x_wr`=0..31 ascending; `busy`=1 for N+1..N+32; cursor=(0,cy+1) at N+1.
- CLEAR/FF: writes at N+1..N+896; `busy`=1 for N+1..N+896; cursor reads (0,0) from N+897.
- `busy` drops in the cycle after the last `we` pulse. A new write is accepted in that same cycle.
- CR and cursor-register writes produce no `we` and no `busy`.

## Test plan
- Reset, then CHAR 0x41 → one `we` pulse at (0,0) with `char_wr`=0x41; cursor (1,0); `busy` never asserts.
- Set cursor (31,27), then CHAR 0x42 → write at (31,27); 32 BLANK writes on row 0; cursor (0,0); `busy` high for 33 cycles.
- CURSOR_X=5, then BS, BS, then CURSOR_X=0 and BS → BLANK writes at (4,y) and (3,y); the final BS produces no write and cursor X stays 0.
- CMD=0x01, with CHAR writes issued during `busy` → exactly 896 BLANK writes covering every cell once; the dropped writes leave no trace; cursor (0,0).
- CURSOR_Y=31 → `cursor_y`=27. Then CHAR 0x9A → write 0x3F. Then CHAR 0x07 → no write, no cursor change.
- Assert `reset` at erase count 10 of an LF → `we`=0 and `busy`=0 immediately; cursor (0,0) after release.
